// File: rtl/alu_arbiter_if.sv
// Requester-side handshake bundle for alu_arbiter: two request ports and their
// shared response bus. Master is the requester side, slave is the arbiter.
interface alu_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int OPW    = 5
);
    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [1:0][DATA_W-1:0] req_a;
    logic [1:0][DATA_W-1:0] req_b;
    logic [1:0][OPW-1:0]    req_op;
    logic [1:0]             resp_valid;
    logic [1:0]             resp_ready;
    logic [DATA_W-1:0]      resp_result;
    logic                   resp_flag;

    modport master (
        output req_valid, req_a, req_b, req_op, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_flag
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, resp_ready,
        output req_ready, resp_valid, resp_result, resp_flag
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two valid/ready requesters;
// the winner's Result/Flag are registered and held until that requester accepts them.
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int OPW    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_arbiter_if.slave      bus,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OPW-1:0]    alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_flag
);
    typedef enum logic {IDLE, RESP} state_t;

    state_t            state;
    logic              owner;
    logic              last_grant;
    logic [1:0]        resp_valid_q;
    logic [DATA_W-1:0] result_q;
    logic              flag_q;

    logic any_valid;
    logic grant;
    logic sel;
    logic take;

    // Contention goes to the port that did not win last; a lone requester always wins.
    assign any_valid = |bus.req_valid;
    assign grant     = (&bus.req_valid) ? ~last_grant : bus.req_valid[1];
    assign take      = (state == IDLE) && any_valid;
    assign sel       = take ? grant : last_grant;

    assign bus.req_ready = take ? (grant ? 2'b10 : 2'b01) : 2'b00;

    assign alu_a  = bus.req_a[sel];
    assign alu_b  = bus.req_b[sel];
    assign alu_op = bus.req_op[sel];

    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_result = result_q;
    assign bus.resp_flag   = flag_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            owner        <= 1'b0;
            last_grant   <= 1'b1;
            resp_valid_q <= 2'b00;
            result_q     <= '0;
            flag_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        result_q     <= alu_result;
                        flag_q       <= alu_flag;
                        owner        <= grant;
                        last_grant   <= grant;
                        resp_valid_q <= grant ? 2'b10 : 2'b01;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    // Only the owning port's ready can release the response.
                    if (bus.resp_ready[owner]) begin
                        resp_valid_q <= 2'b00;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
